// File: rtl/uart_packet_receiver.sv
// uart_packet_receiver
// Parses length-prefixed UART packets (0xA5, LEN_LO, LEN_HI, payload, CHK),
// buffers the payload in a FIFO and only exposes it downstream once the XOR
// checksum matches. Failed or timed-out packets are rolled back.
module uart_packet_receiver #(
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter int unsigned MAX_LEN        = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_data_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       packet_ok,
  output logic       packet_error,
  output logic [1:0] error_code,
  output logic       busy
);

  localparam int unsigned PW       = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_SPACE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t          state_q;
  logic [7:0]      len_lo_q;
  logic [15:0]     remain_q;
  logic [7:0]      xor_q;
  logic [TW-1:0]   tmo_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   commit_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            packet_ok_q;
  logic            packet_error_q;
  logic [1:0]      error_code_q;
  logic            busy_q;
  logic [7:0]      out_data_q;
  logic            out_last_q;
  logic            out_valid_q;

  logic [8:0]      mem [DEPTH];

  logic [31:0]     len_w;
  logic [PW-1:0]   occ_w;
  logic [31:0]     free_w;
  logic            mem_we;
  logic [8:0]      rd_entry;
  logic            slot_load;

  // Length candidate, and free space counting uncommitted bytes as used
  always_comb begin
    len_w     = 32'({in_data, len_lo_q});
    occ_w     = wr_ptr_q - rd_ptr_q;
    free_w    = DEPTH - 32'(occ_w);
    mem_we    = !reset && (state_q == S_PAYLOAD) && in_data_ready;
    rd_entry  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    slot_load = (!out_valid_q || out_ready) && (rd_ptr_q != commit_ptr_q);
  end

  // Parser FSM: framing, checksum, timeout, commit and rollback of wr_ptr
  always_ff @(posedge clk) begin
    packet_ok_q    <= 1'b0;
    packet_error_q <= 1'b0;
    if (reset) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      remain_q     <= '0;
      xor_q        <= '0;
      tmo_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      error_code_q <= '0;
      busy_q       <= 1'b0;
    end else if (state_q == S_IDLE) begin
      tmo_q <= '0;
      if (in_data_ready && (in_data == 8'hA5)) begin
        state_q <= S_LEN_LO;
        xor_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (in_data_ready) begin
      // An arriving byte always takes precedence over a coincident timeout
      tmo_q <= '0;
      case (state_q)
        S_LEN_LO: begin
          len_lo_q <= in_data;
          xor_q    <= xor_q ^ in_data;
          state_q  <= S_LEN_HI;
        end
        S_LEN_HI: begin
          xor_q <= xor_q ^ in_data;
          if ((len_w == 32'd0) || (len_w > MAX_LEN)) begin
            packet_error_q <= 1'b1;
            error_code_q   <= ERR_LENGTH;
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
          end else if (len_w > free_w) begin
            packet_error_q <= 1'b1;
            error_code_q   <= ERR_SPACE;
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
          end else begin
            remain_q <= {in_data, len_lo_q};
            state_q  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          xor_q    <= xor_q ^ in_data;
          wr_ptr_q <= wr_ptr_q + PW'(1);
          remain_q <= remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_data == xor_q) begin
            commit_ptr_q <= wr_ptr_q;
            packet_ok_q  <= 1'b1;
          end else begin
            wr_ptr_q       <= commit_ptr_q;
            packet_error_q <= 1'b1;
            error_code_q   <= ERR_CHECKSUM;
          end
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end else if (tmo_q == TMO_MAX) begin
      wr_ptr_q       <= commit_ptr_q;
      packet_error_q <= 1'b1;
      error_code_q   <= ERR_TIMEOUT;
      tmo_q          <= '0;
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Payload storage: {last, byte}; last marks the final payload byte
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {(remain_q == 16'd1), in_data};
    end
  end

  // Single registered output slot, refilled on the draining cycle for full rate
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (slot_load) begin
      out_data_q  <= rd_entry[7:0];
      out_last_q  <= rd_entry[8];
      out_valid_q <= 1'b1;
      rd_ptr_q    <= rd_ptr_q + PW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_valid    = out_valid_q;
  assign packet_ok    = packet_ok_q;
  assign packet_error = packet_error_q;
  assign error_code   = error_code_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_packet_receiver.sv
// Testbench for uart_packet_receiver: scoreboard of expected payload bytes
// and packet status events, checked by an independent monitor.
module tb_uart_packet_receiver;

  localparam int unsigned DL2  = 4;
  localparam int unsigned ML   = 16;
  localparam int unsigned TMO  = 100;
  localparam int unsigned CAP  = 2 ** DL2;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_data_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       packet_ok;
  logic       packet_error;
  logic [1:0] error_code;
  logic       busy;

  uart_packet_receiver #(
    .DEPTH_LOG2     (DL2),
    .MAX_LEN        (ML),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_data_ready (in_data_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .packet_ok     (packet_ok),
    .packet_error  (packet_error),
    .error_code    (error_code),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected payload bytes {last, data} and expected status events
  // (0..3 = error code, 4 = packet_ok)
  logic [8:0] exp_q[$];
  int         st_q[$];
  logic [7:0] pay[$];

  int ready_mode = 0;  // 0: low, 1: high, 2: random

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Consumer ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something
  initial begin
    logic       prev_stall;
    logic [8:0] prev_val;
    logic [8:0] e;
    int         got_st;
    int         want_st;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", int'({out_valid, out_last, out_data}),
                int'({1'b1, prev_val}));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'({out_last, out_data}), -1);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", int'({out_last, out_data}), int'(e));
          end
        end
        if (packet_ok || packet_error) begin
          got_st = packet_ok ? (packet_error ? 5 : 4) : int'(error_code);
          want_st = (st_q.size() == 0) ? -1 : st_q.pop_front();
          check("status", got_st, want_st);
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = {out_last, out_data};
      end
    end
  end

  task automatic put(input logic [7:0] b, input int unsigned gap);
    in_data       = b;
    in_data_ready = 1'b1;
    @(posedge clk);
    #1;
    in_data_ready = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends 'pay' as a frame; returns right after the CHK-sampling edge
  task automatic send_pkt(input bit bad_chk, input int unsigned maxgap);
    int unsigned n;
    logic [7:0]  chk;
    n   = pay.size();
    chk = 8'(n) ^ 8'(n >> 8);
    foreach (pay[i]) chk ^= pay[i];
    if (bad_chk) begin
      chk ^= 8'(1 << $urandom_range(0, 7));
      st_q.push_back(0);
    end else begin
      foreach (pay[i]) exp_q.push_back({(i == int'(n) - 1), pay[i]});
      st_q.push_back(4);
    end
    put(8'hA5, $urandom_range(0, maxgap));
    put(8'(n), $urandom_range(0, maxgap));
    put(8'(n >> 8), $urandom_range(0, maxgap));
    foreach (pay[i]) put(pay[i], $urandom_range(0, maxgap));
    put(chk, 0);
  endtask

  task automatic make_pay(input int unsigned n);
    pay.delete();
    for (int unsigned i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic wait_drain(input string name);
    int unsigned k;
    k = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, int'(exp_q.size() + st_q.size()), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned k;
    int unsigned room;
    int unsigned good;
    int unsigned r;
    reset         = 1'b1;
    in_data       = '0;
    in_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_outs", int'({out_valid, out_last, packet_ok, packet_error, busy}), 0);
    check("rst_data", int'({error_code, out_data}), 0);

    // Good packet with latency checks
    ready_mode = 1;
    @(posedge clk);
    #1;
    pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(1'b0, 0);
    check("ok_n1", int'(packet_ok), 1);
    check("no_valid_n1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("valid_n2", int'({out_valid, out_data}), int'({1'b1, 8'h11}));
    check("err_code_0", int'(error_code), 0);
    wait_drain("drain_good");

    // Bad checksum followed by the good packet
    send_pkt(1'b1, 1);
    check("bad_chk_pulse", int'({packet_error, error_code}), int'({1'b1, 2'd0}));
    pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(1'b0, 1);
    wait_drain("drain_after_bad");

    // Zero length
    st_q.push_back(1);
    put(8'hA5, 0);
    put(8'h00, 0);
    put(8'h00, 0);
    check("len0_err", int'({packet_error, error_code}), int'({1'b1, 2'd1}));
    // Over MAX_LEN
    st_q.push_back(1);
    put(8'hA5, 0);
    put(8'(ML + 1), 0);
    put(8'h00, 0);
    check("lenmax_err", int'({packet_error, error_code}), int'({1'b1, 2'd1}));
    // Exactly MAX_LEN is accepted
    make_pay(ML);
    send_pkt(1'b0, 0);
    check("lenmax_ok", int'(packet_ok), 1);
    wait_drain("drain_maxlen");

    // Space: 12 committed bytes, nothing consumed
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    make_pay(12);
    send_pkt(1'b0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    st_q.push_back(2);
    put(8'hA5, 0);
    put(8'd6, 0);
    put(8'h00, 0);
    check("space_err", int'({packet_error, error_code}), int'({1'b1, 2'd2}));
    ready_mode = 1;
    wait_drain("drain_space");
    make_pay(5);
    send_pkt(1'b0, 0);
    check("space_ok", int'(packet_ok), 1);
    wait_drain("drain_space2");

    // Timeout mid-payload
    st_q.push_back(3);
    put(8'hA5, 0);
    put(8'h02, 0);
    put(8'h00, 0);
    put(8'hAA, 0);
    check("busy_mid", int'(busy), 1);
    k = 0;
    while (!packet_error && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", int'(k), int'(TMO + 1));
    check("tmo_code", int'({packet_error, error_code, busy}), int'({1'b1, 2'd3, 1'b0}));
    make_pay(4);
    send_pkt(1'b0, 2);
    wait_drain("drain_tmo");

    // Random traffic with backpressure across pointer wrap
    ready_mode = 2;
    good = 0;
    while (good < 40) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        put(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 2));
      end else if (r == 1) begin
        st_q.push_back(1);
        k = $urandom_range(ML + 1, 700);
        put(8'hA5, 0);
        put(8'(k), 1);
        put(8'(k >> 8), 1);
      end else begin
        k = 0;
        while (exp_q.size() >= CAP && k < 1000) begin
          @(posedge clk);
          #1;
          k++;
        end
        if (k >= 1000) check("room_wait", int'(exp_q.size()), 0);
        room = CAP - exp_q.size();
        if (room > 8) room = 8;
        make_pay($urandom_range(1, room));
        if (r == 2) begin
          send_pkt(1'b1, 2);
        end else begin
          send_pkt(1'b0, 2);
          good++;
        end
      end
    end
    ready_mode = 1;
    wait_drain("drain_random");

    // Reset mid-payload discards everything
    put(8'hA5, 0);
    put(8'h04, 0);
    put(8'h00, 0);
    put(8'h01, 0);
    put(8'h02, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_outs", int'({out_valid, out_last, packet_ok, packet_error, busy}), 0);
    check("rst_mid_data", int'({error_code, out_data}), 0);
    make_pay(3);
    send_pkt(1'b0, 1);
    check("after_rst_ok", int'(packet_ok), 1);
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_packet_receiver.md
# uart_packet_receiver

Framing and buffering stage between `uart_receiver` and the program-load path. It consumes raw UART bytes, parses length-prefixed packets, and validates each packet with an XOR checksum. Payload bytes are held in an internal FIFO and become visible downstream only after the whole packet passes validation. A failed packet is rolled back, so the consumer never sees a partial or corrupt packet.

## Interface
- `DEPTH_LOG2`, default 8: FIFO holds 2^DEPTH_LOG2 payload bytes.
- `MAX_LEN`, default 256: largest accepted payload length. Must be ≤ 2^DEPTH_LOG2.
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte timeout while mid-packet. Counter width is $clog2(TIMEOUT_CYCLES+1).
- `clk`  in  1  system clock. One clock domain; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  byte from `uart_receiver`.
- `in_data_ready`  in  1  single-cycle strobe; `in_data` is valid in this cycle.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  marks the final byte of a packet.
- `out_valid`  out  1  `out_data`/`out_last` are valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid && out_ready`.
- `packet_ok`  out  1  single-cycle pulse when a packet is committed.
- `packet_error`  out  1  single-cycle pulse when a packet is discarded.
- `error_code`  out  2  reason for the discard. 0 checksum, 1 bad length, 2 no space, 3 timeout. Holds its value until the next error.
- `busy`  out  1  high when the parser is in any state other than IDLE.

## Operation
- Frame format: 0xA5, LEN_LO, LEN_HI, LEN payload bytes, CHK.
- CHK = XOR of LEN_LO, LEN_HI and all payload bytes.
- Parser FSM states: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK.
- IDLE: a byte equal to 0xA5 moves the FSM to LEN_LO. Any other byte is dropped silently with no error.
- LEN_LO: store the byte, go to LEN_HI.
- LEN_HI: form LEN = {LEN_HI, LEN_LO} and apply these checks in this order:
  - LEN == 0 or LEN > MAX_LEN → error 1, go to IDLE.
  - LEN > free space → error 2, go to IDLE.
  - Otherwise load the remaining-count with LEN and go to PAYLOAD.
- PAYLOAD: write each byte at `wr_ptr` and increment `wr_ptr`. Set the entry's last flag when remaining-count == 1. When the last byte is written, go to CHECK.
- CHECK: the next byte is CHK.
  - Match → `commit_ptr <= wr_ptr`, pulse `packet_ok`.
  - Mismatch → `wr_ptr <= commit_ptr` (rollback), error 0.
  - Either way, go to IDLE.
- The running XOR clears on the 0xA5 byte and accumulates LEN_LO, LEN_HI and every payload byte.
- Timeout: the counter clears on every `in_data_ready` and on entry to LEN_LO. If the FSM is in any non-IDLE state and the counter reaches TIMEOUT_CYCLES, roll back, raise error 3 and go to IDLE.
- FIFO storage: 9-bit entries {last, byte}.
- Pointers `wr_ptr`, `commit_ptr`, `rd_ptr` are DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
- Occupancy = `wr_ptr − rd_ptr`; free = 2^DEPTH_LOG2 − occupancy. The space check therefore counts uncommitted bytes as used.
- The read side sees only `rd_ptr` up to `commit_ptr`. Consumer reads proceed concurrently with parsing of the next packet.
- Output stage: a single registered slot.
  - It loads from `mem[rd_ptr]` when it is empty, or when it is being drained this cycle, and `rd_ptr != commit_ptr`.
  - This sustains one byte per cycle under continuous `out_ready`.

## Timing
- Reset values:
  - FSM = IDLE.
  - All pointers = 0.
  - `out_valid`, `out_last`, `packet_ok`, `packet_error`, `busy` = 0.
  - `error_code` = 0, `out_data` = 0.
  - Timeout counter = 0, XOR accumulator = 0.
- Reset mid-packet or mid-drain discards all data, committed and uncommitted, in the same edge.
- A CHK byte strobed in cycle N produces `packet_ok` or `packet_error` in cycle N+1; `commit_ptr` is updated at the same edge.
- With an empty output slot, the earliest `out_valid` is cycle N+2.
- A length or space error is flagged in the cycle after the LEN_HI strobe.
- The consumer may hold `out_ready` low indefinitely. `out_data`/`out_last` must stay stable while `out_valid && !out_ready`.
- A rollback never moves `rd_ptr` and never disturbs the output slot.
- Simultaneous `in_data_ready` and timeout expiry: the byte wins and the counter clears.
- A full FIFO never blocks the parser: space is checked only at LEN_HI, and input has no backpressure.

## Test plan
- Good packet: A5 03 00 11 22 33 03 → `packet_ok` at N+1; outputs 11, 22, 33 with `out_last` only on 33; `error_code` stays 0.
- Bad checksum: A5 03 00 11 22 33 04, then the good packet → `packet_error`, code 0. Only the second packet's 11 22 33 appears; the FIFO shows no residue.
- Length and space: A5 00 00 → error 1. With DEPTH_LOG2=4 and MAX_LEN=16, commit 12 bytes without draining, then send LEN=5 → error 2. Drain 12 bytes, resend LEN=5 → `packet_ok`.
- Timeout: with TIMEOUT_CYCLES=100, send A5 02 00 AA and go silent → `packet_error` code 3 at the expiry cycle. `busy` drops, and a following valid packet is accepted.
- Backpressure and wrap: stream 40 valid packets through a DEPTH_LOG2=4 FIFO with random `out_ready` → byte order and `out_last` positions match the model across pointer wrap, and data stays stable while stalled.
- Reset mid-payload: after A5 04 00 01 02, assert `reset` for one cycle → all outputs are 0, then the next valid packet is received correctly.
